// File: rtl/riscv_pkg.sv
// Shared encodings for the memory access stage: func3 access sizes and FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  // Unsupported encodings fall through to a full-word access.
  function automatic size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_LB, F3_LBU: return SZ_B;
      F3_LH, F3_LHU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend
// and alignment check for one access.
module load_store_align
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BE_WIDTH = 4
) (
  input  logic [2:0]          i_func3,
  input  logic [1:0]          i_lane,
  input  logic [XLEN-1:0]     i_store_data,
  input  logic [XLEN-1:0]     i_read_data,
  output logic [BE_WIDTH-1:0] o_byteen,
  output logic [XLEN-1:0]     o_writedata,
  output logic [XLEN-1:0]     o_load_data,
  output logic                o_misaligned
);

  size_e              w_size;
  logic               w_unsigned;
  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  function automatic logic [XLEN-1:0] ext_byte(input logic signed [7:0] b, input logic zx);
    return zx ? XLEN'($unsigned(b)) : XLEN'(b);
  endfunction

  function automatic logic [XLEN-1:0] ext_half(input logic signed [15:0] h, input logic zx);
    return zx ? XLEN'($unsigned(h)) : XLEN'(h);
  endfunction

  assign w_size     = f3_size(i_func3);
  assign w_unsigned = i_func3[2];
  assign w_byte     = 8'(i_read_data >> {i_lane, 3'b000});
  assign w_half     = i_lane[1] ? i_read_data[XLEN-1:XLEN/2] : i_read_data[XLEN/2-1:0];

  always_comb begin
    o_byteen     = '0;
    o_writedata  = i_store_data;
    o_load_data  = '0;
    o_misaligned = 1'b0;
    case (w_size)
      SZ_B: begin
        o_byteen    = BE_WIDTH'(1) << i_lane;
        o_writedata = {BE_WIDTH{i_store_data[7:0]}};
        o_load_data = ext_byte(w_byte, w_unsigned);
      end
      SZ_H: begin
        o_byteen     = i_lane[1] ? 4'b1100 : 4'b0011;
        o_writedata  = {2{i_store_data[XLEN/2-1:0]}};
        o_load_data  = ext_half(w_half, w_unsigned);
        o_misaligned = i_lane[0];
      end
      default: begin
        o_byteen     = '1;
        o_writedata  = i_store_data;
        o_load_data  = i_read_data;
        o_misaligned = |i_lane;
      end
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// MEM stage: runs one load/store at a time against the data cache and stalls the
// pipeline until the busywait handshake completes.
module memory_access_unit
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BE_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [2:0]          func3,
  input  logic [XLEN-1:0]     address,
  input  logic [XLEN-1:0]     store_data,
  output logic                dmem_read,
  output logic                dmem_write,
  output logic [XLEN-1:0]     dmem_address,
  output logic [XLEN-1:0]     dmem_writedata,
  output logic [BE_WIDTH-1:0] dmem_byteen,
  input  logic [XLEN-1:0]     dmem_readdata,
  input  logic                dmem_busywait,
  output logic [XLEN-1:0]     load_data,
  output logic                load_valid,
  output logic                stall,
  output logic                misaligned
);

  logic [1:0]          r_state;
  logic [XLEN-1:0]     r_addr;
  logic [2:0]          r_func3;
  logic                r_is_store;
  logic                r_mis;
  logic [BE_WIDTH-1:0] r_byteen;
  logic [XLEN-1:0]     r_wdata;
  logic [XLEN-1:0]     r_load_data;

  logic                w_idle;
  logic                w_access;
  logic                w_done;
  logic                w_req;
  logic [2:0]          w_func3;
  logic [1:0]          w_lane;
  logic [BE_WIDTH-1:0] w_byteen;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_load_ext;
  logic                w_mis;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_ACCESS);
  assign w_done   = (r_state == ST_DONE);
  assign w_req    = mem_read | mem_write;

  // The aligner sees the live request while idle and the captured one afterwards.
  assign w_func3 = w_idle ? func3 : r_func3;
  assign w_lane  = w_idle ? address[1:0] : r_addr[1:0];

  load_store_align #(
    .XLEN     (XLEN),
    .BE_WIDTH (BE_WIDTH)
  ) u_align (
    .i_func3      (w_func3),
    .i_lane       (w_lane),
    .i_store_data (store_data),
    .i_read_data  (dmem_readdata),
    .o_byteen     (w_byteen),
    .o_writedata  (w_wdata),
    .o_load_data  (w_load_ext),
    .o_misaligned (w_mis)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_func3     <= '0;
      r_is_store  <= 1'b0;
      r_mis       <= 1'b0;
      r_byteen    <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr     <= address;
            r_func3    <= func3;
            r_is_store <= mem_write;
            r_mis      <= w_mis;
            r_byteen   <= w_byteen;
            r_wdata    <= w_wdata;
            if (w_mis) begin
              r_load_data <= '0;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (!dmem_busywait) begin
            if (!r_is_store) r_load_data <= w_load_ext;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dmem_read      = w_access & ~r_is_store;
  assign dmem_write     = w_access & r_is_store;
  assign dmem_address   = {r_addr[XLEN-1:2], 2'b00};
  assign dmem_writedata = r_wdata;
  assign dmem_byteen    = r_byteen;
  assign load_data      = r_load_data;
  assign load_valid     = w_done & ~r_is_store & ~r_mis;
  assign misaligned     = w_done & r_mis;
  assign stall          = (w_idle & w_req & ~RESET) | w_access;

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: a transaction-level model predicts every
// output cycle by cycle, and literal values pin the key cases.
module tb_memory_access_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read, mem_write;
  logic [2:0]  func3;
  logic [31:0] address, store_data;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_writedata;
  logic [3:0]  dmem_byteen;
  logic [31:0] dmem_readdata;
  logic        dmem_busywait;
  logic [31:0] load_data;
  logic        load_valid, stall, misaligned;

  always #5 CLK = ~CLK;

  memory_access_unit dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .func3          (func3),
    .address        (address),
    .store_data     (store_data),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_address   (dmem_address),
    .dmem_writedata (dmem_writedata),
    .dmem_byteen    (dmem_byteen),
    .dmem_readdata  (dmem_readdata),
    .dmem_busywait  (dmem_busywait),
    .load_data      (load_data),
    .load_valid     (load_valid),
    .stall          (stall),
    .misaligned     (misaligned)
  );

  typedef struct {
    logic        stall, rd, wr, lv, mis, chk_be, chk_wd, chk_ld;
    logic [31:0] ad, wd, ld;
    logic [3:0]  be;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          c_stall = 0, c_rd = 0, c_wr_rise = 0, c_lv = 0, c_mis = 0;
  logic        prev_wr = 1'b0;
  logic [31:0] m_ld;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("stall", 32'(stall), 32'(cur.stall));
      chk("dmem_read", 32'(dmem_read), 32'(cur.rd));
      chk("dmem_write", 32'(dmem_write), 32'(cur.wr));
      chk("load_valid", 32'(load_valid), 32'(cur.lv));
      chk("misaligned", 32'(misaligned), 32'(cur.mis));
      if (cur.chk_be) begin
        chk("dmem_address", dmem_address, cur.ad);
        chk("dmem_byteen", 32'(dmem_byteen), 32'(cur.be));
      end
      if (cur.chk_wd) chk("dmem_writedata", dmem_writedata, cur.wd);
      if (cur.chk_ld) chk("load_data", load_data, cur.ld);
    end
    if (stall === 1'b1) c_stall++;
    if (dmem_read === 1'b1) c_rd++;
    if (dmem_write === 1'b1 && prev_wr !== 1'b1) c_wr_rise++;
    prev_wr = dmem_write;
    if (load_valid === 1'b1) c_lv++;
    if (misaligned === 1'b1) c_mis++;
  end

  function automatic int msize(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  task automatic cyc(input exp_t e);
    q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_counts();
    c_stall = 0; c_rd = 0; c_wr_rise = 0; c_lv = 0; c_mis = 0;
  endtask

  // One request held until its completion cycle, then a quiet cycle.
  task automatic do_txn(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] ad, input logic [31:0] sd,
                        input logic [31:0] rdata, input int nbusy);
    int          sz;
    logic        st, mis;
    logic [3:0]  be;
    logic [31:0] wd, ld, mk;
    exp_t        e;
    sz  = msize(f3);
    st  = wr;
    mis = (ad % 32'(sz)) != 0;
    be  = 4'(((1 << sz) - 1) << (ad & 32'd3));
    mk  = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    wd  = (sz == 1) ? {24'b0, sd[7:0]} * 32'h0101_0101 :
          (sz == 2) ? {16'b0, sd[15:0]} * 32'h0001_0001 : sd;
    ld  = (rdata >> (8 * (ad & 32'd3))) & mk;
    if (sz < 4 && !f3[2] && ld[8*sz-1]) ld = ld | ~mk;

    clr_counts();
    mem_read = rd; mem_write = wr; func3 = f3; address = ad;
    store_data = sd; dmem_readdata = rdata; dmem_busywait = 1'b0;
    e = '{default: 0}; e.stall = 1; e.chk_ld = 1; e.ld = m_ld;
    cyc(e);
    if (mis) begin
      m_ld = 32'h0;
      e = '{default: 0}; e.mis = 1; e.chk_ld = 1; e.ld = m_ld;
      cyc(e);
    end else begin
      for (int k = 1; k <= nbusy + 1; k++) begin
        dmem_busywait = (k <= nbusy);
        e = '{default: 0};
        e.stall = 1; e.rd = !st; e.wr = st;
        e.chk_be = 1; e.ad = ad & 32'hFFFF_FFFC; e.be = be;
        e.chk_wd = st; e.wd = wd; e.chk_ld = 1; e.ld = m_ld;
        cyc(e);
      end
      dmem_busywait = 1'b0;
      if (!st) m_ld = ld;
      e = '{default: 0}; e.lv = !st; e.chk_ld = 1; e.ld = m_ld;
      cyc(e);
    end
    mem_read = 1'b0; mem_write = 1'b0;
    e = '{default: 0}; e.chk_ld = 1; e.ld = m_ld;
    cyc(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    RESET = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000;
    address = '0; store_data = '0; dmem_readdata = '0; dmem_busywait = 1'b0;
    m_ld = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    e = '{default: 0};
    e.chk_be = 1; e.chk_wd = 1; e.chk_ld = 1;
    cyc(e);
    RESET = 1'b0;
    cyc(e);

    do_txn(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
    chk("lb_load_data", load_data, 32'hFFFF_FF80);
    chk("lb_stall_cycles", 32'(c_stall), 32'd2);
    chk("lb_valid_pulses", 32'(c_lv), 32'd1);

    do_txn(1'b1, 1'b0, 3'b101, 32'h0000_1002, 32'h0, 32'hBEEF_1234, 0);
    chk("lhu_load_data", load_data, 32'h0000_BEEF);

    do_txn(1'b0, 1'b1, 3'b000, 32'h0000_2001, 32'h1234_56AB, 32'h0, 0);
    chk("sb_byteen", 32'(dmem_byteen), 32'h2);
    chk("sb_writedata", dmem_writedata, 32'hABAB_ABAB);
    chk("sb_address", dmem_address, 32'h0000_2000);
    chk("sb_writes", 32'(c_wr_rise), 32'd1);
    chk("sb_load_data_held", load_data, 32'h0000_BEEF);

    do_txn(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 32'hFFFF_FFFF, 0);
    chk("lw_mis_pulses", 32'(c_mis), 32'd1);
    chk("lw_mis_reads", 32'(c_rd), 32'd0);
    chk("lw_mis_stall_cycles", 32'(c_stall), 32'd1);
    chk("lw_mis_valid_pulses", 32'(c_lv), 32'd0);
    chk("lw_mis_load_data", load_data, 32'h0);

    do_txn(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'h1122_3344, 32'h0, 3);
    chk("sw_busy_stall_cycles", 32'(c_stall), 32'd5);
    chk("sw_busy_writes", 32'(c_wr_rise), 32'd1);
    chk("sw_busy_writedata", dmem_writedata, 32'h1122_3344);

    do_txn(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_0000, 0);
    chk("lh_load_data", load_data, 32'hFFFF_8001);
    do_txn(1'b1, 1'b0, 3'b100, 32'h0000_1001, 32'h0, 32'h0000_F500, 1);
    chk("lbu_load_data", load_data, 32'h0000_00F5);

    do_txn(1'b1, 1'b1, 3'b001, 32'h0000_5002, 32'h0000_CAFE, 32'h0, 0);
    chk("rw_sh_byteen", 32'(dmem_byteen), 32'hC);
    chk("rw_sh_writedata", dmem_writedata, 32'hCAFE_CAFE);
    chk("rw_sh_reads", 32'(c_rd), 32'd0);
    chk("rw_sh_load_data_held", load_data, 32'h0000_00F5);

    do_txn(1'b0, 1'b1, 3'b001, 32'h0000_5001, 32'h0000_BEAD, 32'h0, 0);
    chk("sh_mis_pulses", 32'(c_mis), 32'd1);
    do_txn(1'b1, 1'b0, 3'b111, 32'h0000_6002, 32'h0, 32'h8000_0001, 0);
    chk("f3_111_mis_pulses", 32'(c_mis), 32'd1);
    do_txn(1'b1, 1'b0, 3'b111, 32'h0000_6000, 32'h0, 32'h8000_0001, 0);
    chk("f3_111_load_data", load_data, 32'h8000_0001);

    clr_counts();
    mem_read = 1'b1; func3 = 3'b010; address = 32'h0000_7000;
    dmem_readdata = 32'h1234_5678; dmem_busywait = 1'b1;
    e = '{default: 0}; e.stall = 1; e.chk_ld = 1; e.ld = m_ld;
    cyc(e);
    e = '{default: 0}; e.stall = 1; e.rd = 1; e.chk_be = 1;
    e.ad = 32'h0000_7000; e.be = 4'hF; e.chk_ld = 1; e.ld = m_ld;
    cyc(e);
    RESET = 1'b1;
    cyc(e);
    RESET = 1'b0; mem_read = 1'b0; dmem_busywait = 1'b0; m_ld = 32'h0;
    e = '{default: 0}; e.chk_be = 1; e.chk_wd = 1; e.chk_ld = 1;
    cyc(e);
    cyc(e);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_valid_pulses", 32'(c_lv), 32'd0);
    chk("rst_stall_cycles", 32'(c_stall), 32'd3);

    do_txn(1'b1, 1'b0, 3'b100, 32'h0000_7003, 32'h0, 32'hAA00_0000, 0);
    chk("post_rst_lbu_load_data", load_data, 32'h0000_00AA);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
